mdu_alu_sequencer: RTL

// Multi-cycle MULT/MULTU/DIV/DIVU unit that reuses the shared ula.
// - Idle: passes the core's ALU operands and op through to the ALU unchanged.
// - Accepted op: takes the ALU for the full operation, one ALU op per cycle.
// - Result lands in HI/LO.
// - Sits between the decode/execute stage and the single ALU instance.

---
 rtl/mdu_alu_sequencer_pkg.sv | 33 +++
 rtl/mdu_alu_sequencer_alu_port_mux.sv | 30 +++
 rtl/mdu_alu_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_alu_sequencer_pkg.sv
// Shared ALU op codes, multiply/divide op codes and sequencer state encoding
// for the multi-cycle MDU that borrows the core's single ALU.
package mdu_alu_sequencer_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    MdMult  = 2'b00,
    MdMultu = 2'b01,
    MdDiv   = 2'b10,
    MdDivu  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StNegA,
    StNegB,
    StIter,
    StFixLo,
    StFixHi,
    StDone
  } mds_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_alu_sequencer_alu_port_mux.sv
// ALU port mux: hands the shared ALU to the core when idle, to the MDU
// sequencer while it owns the ALU.
module mdu_alu_sequencer_alu_port_mux #(
  parameter int unsigned W = 32
) (
  input  logic         seq_own_i,
  input  logic [W-1:0] core_in1_i,
  input  logic [W-1:0] core_in2_i,
  input  logic [3:0]   core_op_i,
  input  logic [W-1:0] seq_in1_i,
  input  logic [W-1:0] seq_in2_i,
  input  logic [3:0]   seq_op_i,
  output logic [W-1:0] alu_in1_o,
  output logic [W-1:0] alu_in2_o,
  output logic [3:0]   alu_op_o
);

  always_comb begin
    if (seq_own_i) begin
      alu_in1_o = seq_in1_i;
      alu_in2_o = seq_in2_i;
      alu_op_o  = seq_op_i;
    end else begin
      alu_in1_o = core_in1_i;
      alu_in2_o = core_in2_i;
      alu_op_o  = core_op_i;
    end
  end

endmodule

// File: rtl/mdu_alu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. Signed ops work on magnitudes and
// fix up signs afterwards; every arithmetic step goes through the shared ALU.
module mdu_alu_sequencer
  import mdu_alu_sequencer_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   md_op,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  input  logic [W-1:0] core_in1,
  input  logic [W-1:0] core_in2,
  input  logic [3:0]   core_op,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_result,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CntW = $clog2(ITERS);
  localparam logic [CntW-1:0] CntLast = CntW'(ITERS - 1);

  mds_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic          is_div_q, is_div_d, is_signed_q, is_signed_d;
  logic          lo_zero_q, lo_zero_d;
  logic          dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;

  logic [W-1:0]  seq_in1, seq_in2;
  logic [3:0]    seq_op;
  logic [W-1:0]  rem_sh;
  logic          div_ge, negate;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    lo_zero_d   = lo_zero_q;
    dbz_d       = dbz_q;
    seq_in1     = '0;
    seq_in2     = '0;
    seq_op      = ALU_ADD;
    rem_sh      = {hi_q[W-2:0], lo_q[W-1]};
    div_ge      = 1'b0;
    negate      = sign_a_q ^ sign_b_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          dbz_d       = 1'b0;
          is_div_d    = md_is_div(md_op);
          is_signed_d = md_is_signed(md_op);
          a_d         = rs;
          b_d         = rt;
          sign_a_d    = 1'b0;
          sign_b_d    = 1'b0;
          cnt_d       = '0;
          if (md_is_div(md_op) && (rt == '0)) begin
            state_d = StDone;
            hi_d    = rs;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            // Unsigned ops start iterating next cycle, so seed accumulators now.
            hi_d    = '0;
            lo_d    = md_is_div(md_op) ? rs : rt;
            state_d = md_is_signed(md_op) ? StNegA : StIter;
          end
        end
      end
      StNegA: begin
        seq_in2  = a_q;
        seq_op   = ALU_SUB;
        sign_a_d = a_q[W-1];
        a_d      = a_q[W-1] ? alu_result : a_q;
        if (is_div_q) lo_d = a_d;
        state_d  = StNegB;
      end
      StNegB: begin
        seq_in2  = b_q;
        seq_op   = ALU_SUB;
        sign_b_d = b_q[W-1];
        b_d      = b_q[W-1] ? alu_result : b_q;
        if (!is_div_q) lo_d = b_d;
        hi_d     = '0;
        cnt_d    = '0;
        state_d  = StIter;
      end
      StIter: begin
        if (is_div_q) begin
          seq_in1 = rem_sh;
          seq_in2 = b_q;
          seq_op  = ALU_SUB;
          // A set top bit means the shifted remainder exceeds any W-bit divisor.
          div_ge  = hi_q[W-1] | (rem_sh >= b_q);
          hi_d    = div_ge ? alu_result : rem_sh;
          lo_d    = {lo_q[W-2:0], div_ge};
        end else begin
          seq_in1 = hi_q;
          seq_in2 = lo_q[0] ? a_q : '0;
          seq_op  = ALU_ADD;
          hi_d    = {(alu_result < seq_in2), alu_result[W-1:1]};
          lo_d    = {alu_result[0], lo_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = is_signed_q ? StFixLo : StDone;
      end
      StFixLo: begin
        seq_in2   = lo_q;
        seq_op    = ALU_SUB;
        lo_zero_d = (lo_q == '0);
        if (negate) lo_d = alu_result;
        state_d   = StFixHi;
      end
      StFixHi: begin
        if (is_div_q) begin
          seq_in2 = hi_q;
          seq_op  = ALU_SUB;
          if (sign_a_q) hi_d = alu_result;
        end else begin
          // Two's complement of the 64-bit product: carry into HI only when LO was 0.
          seq_in1 = ~hi_q;
          seq_in2 = {{(W-1){1'b0}}, lo_zero_q};
          seq_op  = ALU_ADD;
          if (negate) hi_d = alu_result;
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    busy_d = !((state_d == StIdle) || (state_d == StDone));
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      lo_zero_q   <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      lo_zero_q   <= lo_zero_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  mdu_alu_sequencer_alu_port_mux #(
    .W (W)
  ) u_alu_port_mux (
    .seq_own_i  (busy_q),
    .core_in1_i (core_in1),
    .core_in2_i (core_in2),
    .core_op_i  (core_op),
    .seq_in1_i  (seq_in1),
    .seq_in2_i  (seq_in2),
    .seq_op_i   (seq_op),
    .alu_in1_o  (alu_in1),
    .alu_in2_o  (alu_in2),
    .alu_op_o   (alu_op)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
